// File: rtl/rvfi_commit_tracer_pkg.sv
// Shared types for the RVFI commit tracer: the retirement packet layout,
// the capture FSM encoding and default sizing.
package rvfi_commit_tracer_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [1:0]  ixl;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_word;

  typedef enum logic [1:0] {
    TRACER_IDLE    = 2'd0,
    TRACER_ARMED   = 2'd1,
    TRACER_CAPTURE = 2'd2,
    TRACER_DONE    = 2'd3
  } tracer_state_t;

  localparam int TRACER_DEPTH   = 16;
  localparam int TRACER_CNT_W   = 16;
  localparam int TRACER_ORDER_W = 64;

endpackage

// File: rtl/rvfi_commit_tracer_trace_fifo.sv
// Circular FIFO of RVFI packets; the head is read straight from registered
// storage so a pushed entry appears one cycle after the push.
module rvfi_commit_tracer_trace_fifo
  import rvfi_commit_tracer_pkg::*;
#(
  parameter int DEPTH = TRACER_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  rvfi_word                   din,
  output rvfi_word                   dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  rvfi_word           mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [OCC_W-1:0]   occ_reg;
  logic               do_push;
  logic               do_pop;

  always_comb begin
    full    = (occ_reg == OCC_W'(DEPTH));
    empty   = (occ_reg == '0);
    do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ_reg <= occ_reg + OCC_W'(1);
        2'b01:   occ_reg <= occ_reg - OCC_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign dout      = mem_reg[rd_ptr_reg];
  assign occupancy = occ_reg;

endmodule

// File: rtl/rvfi_commit_tracer.sv
// Stamps retiring RVFI packets with an order number, filters them through a
// PC-trigger / capture-limit FSM and queues accepted ones for a trace consumer.
module rvfi_commit_tracer
  import rvfi_commit_tracer_pkg::*;
#(
  parameter int DEPTH   = TRACER_DEPTH,
  parameter int CNT_W   = TRACER_CNT_W,
  parameter int ORDER_W = TRACER_ORDER_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  input  logic                   cfg_trig_en,
  input  logic [31:0]            cfg_trig_pc,
  input  logic [CNT_W-1:0]       cfg_limit,
  input  logic                   commit_valid,
  input  rvfi_word               commit_word,
  input  logic                   trace_ready,
  output logic                   trace_valid,
  output rvfi_word               trace_word,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       capture_cnt,
  output logic [1:0]             state_o,
  output logic                   done
);

  tracer_state_t      state_reg;
  tracer_state_t      state_next;
  logic [ORDER_W-1:0] order_reg;
  logic [CNT_W-1:0]   capture_cnt_reg;
  logic [CNT_W-1:0]   drop_cnt_reg;
  logic               overflow_reg;

  logic               fifo_full;
  logic               fifo_empty;
  logic               trig_hit;
  logic               eligible;
  logic               pop;
  logic               push;
  logic               drop;
  logic               start_ok;
  logic               limit_hit;
  logic [CNT_W-1:0]   capture_inc;
  rvfi_word           stamped_word;

  always_comb begin
    trig_hit    = commit_valid && (commit_word.pc_rdata == cfg_trig_pc);
    eligible    = (commit_valid && (state_reg == TRACER_CAPTURE)) ||
                  (trig_hit && (state_reg == TRACER_ARMED));
    pop         = trace_valid && trace_ready;
    push        = eligible && (!fifo_full || pop);
    drop        = eligible && fifo_full && !pop;
    capture_inc = (&capture_cnt_reg) ? capture_cnt_reg : capture_cnt_reg + CNT_W'(1);
    // The packet that brings the count up to the limit is the last one taken.
    limit_hit   = eligible && (cfg_limit != '0) && (capture_inc == cfg_limit);
    start_ok    = cfg_start && !cfg_abort &&
                  ((state_reg == TRACER_IDLE) || (state_reg == TRACER_DONE));

    state_next = state_reg;
    if (cfg_abort) begin
      state_next = TRACER_IDLE;
    end else begin
      case (state_reg)
        TRACER_IDLE, TRACER_DONE: begin
          if (cfg_start) state_next = cfg_trig_en ? TRACER_ARMED : TRACER_CAPTURE;
        end
        TRACER_ARMED: begin
          if (eligible) state_next = limit_hit ? TRACER_DONE : TRACER_CAPTURE;
        end
        TRACER_CAPTURE: begin
          if (limit_hit) state_next = TRACER_DONE;
        end
        default: state_next = TRACER_IDLE;
      endcase
    end

    stamped_word       = commit_word;
    stamped_word.order = 64'(order_reg);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= TRACER_IDLE;
      order_reg       <= '0;
      capture_cnt_reg <= '0;
      drop_cnt_reg    <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Every retirement advances the order, so filtered packets leave gaps.
      if (commit_valid) order_reg <= order_reg + ORDER_W'(1);
      if (start_ok) begin
        capture_cnt_reg <= '0;
      end else if (eligible) begin
        capture_cnt_reg <= capture_inc;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (!(&drop_cnt_reg)) drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      end
    end
  end

  rvfi_commit_tracer_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .din       (stamped_word),
    .dout      (trace_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  assign trace_valid = !fifo_empty;
  assign overflow    = overflow_reg;
  assign drop_cnt    = drop_cnt_reg;
  assign capture_cnt = capture_cnt_reg;
  assign state_o     = state_reg;
  assign done        = (state_reg == TRACER_DONE);

endmodule

// File: tb/tb_rvfi_commit_tracer.sv
// Directed bench for rvfi_commit_tracer: trigger, overflow, limit, abort and
// reset scenarios with hand-computed expected orders and counters.
module tb_rvfi_commit_tracer;
  import rvfi_commit_tracer_pkg::*;

  localparam int DEPTH   = 16;
  localparam int CNT_W   = 16;
  localparam int ORDER_W = 64;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   cfg_start;
  logic                   cfg_abort;
  logic                   cfg_trig_en;
  logic [31:0]            cfg_trig_pc;
  logic [CNT_W-1:0]       cfg_limit;
  logic                   commit_valid;
  rvfi_word               commit_word;
  logic                   trace_ready;
  logic                   trace_valid;
  rvfi_word               trace_word;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   overflow;
  logic [CNT_W-1:0]       drop_cnt;
  logic [CNT_W-1:0]       capture_cnt;
  logic [1:0]             state_o;
  logic                   done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rvfi_commit_tracer #(
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .ORDER_W (ORDER_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_trig_en  (cfg_trig_en),
    .cfg_trig_pc  (cfg_trig_pc),
    .cfg_limit    (cfg_limit),
    .commit_valid (commit_valid),
    .commit_word  (commit_word),
    .trace_ready  (trace_ready),
    .trace_valid  (trace_valid),
    .trace_word   (trace_word),
    .occupancy    (occupancy),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .capture_cnt  (capture_cnt),
    .state_o      (state_o),
    .done         (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic commit_one(input logic [31:0] pc);
    @(negedge clk);
    commit_valid         = 1'b1;
    commit_word          = '0;
    commit_word.valid    = 1'b1;
    commit_word.insn     = 32'h0000_0013;
    commit_word.order    = 64'hdead_beef;
    commit_word.pc_rdata = pc;
    commit_word.pc_wdata = pc + 32'd4;
    @(posedge clk);
    #1 commit_valid = 1'b0;
    $display("commit pc=0x%08h", pc);
  endtask

  task automatic pulse_start(input logic trig_en);
    @(negedge clk);
    cfg_start   = 1'b1;
    cfg_trig_en = trig_en;
    @(posedge clk);
    #1 cfg_start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    cfg_abort = 1'b1;
    @(posedge clk);
    #1 cfg_abort = 1'b0;
  endtask

  // Pops n packets, expecting consecutive orders from first, then an empty FIFO.
  task automatic drain_seq(input string tag, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, ".valid"}, 64'(trace_valid), 64'd1);
      check({tag, ".order"}, trace_word.order, 64'(first + i));
      $display("pop order=%0d pc=0x%08h", trace_word.order, trace_word.pc_rdata);
      trace_ready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    trace_ready = 1'b0;
    check({tag, ".empty"}, 64'(trace_valid), 64'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    cfg_start    = 1'b0;
    cfg_abort    = 1'b0;
    cfg_trig_en  = 1'b0;
    cfg_trig_pc  = 32'h6000_0010;
    cfg_limit    = '0;
    commit_valid = 1'b0;
    commit_word  = '0;
    trace_ready  = 1'b0;

    do_reset();
    check("rst.state", 64'(state_o), 64'd0);
    check("rst.valid", 64'(trace_valid), 64'd0);
    check("rst.occ", 64'(occupancy), 64'd0);
    check("rst.ovf", 64'(overflow), 64'd0);
    check("rst.drop", 64'(drop_cnt), 64'd0);
    check("rst.cap", 64'(capture_cnt), 64'd0);
    check("rst.done", 64'(done), 64'd0);

    // Untriggered capture streaming straight through to a ready consumer.
    trace_ready = 1'b1;
    pulse_start(1'b0);
    check("t1.state", 64'(state_o), 64'd2);
    for (int i = 0; i < 5; i++) begin
      commit_one(32'h0000_1000 + 32'(4 * i));
      check("t1.valid", 64'(trace_valid), 64'd1);
      check("t1.order", trace_word.order, 64'(i));
      check("t1.pc", 64'(trace_word.pc_rdata), 64'(32'h0000_1000 + 32'(4 * i)));
    end
    @(posedge clk);
    #1;
    check("t1.drained", 64'(trace_valid), 64'd0);
    check("t1.cap", 64'(capture_cnt), 64'd5);
    trace_ready = 1'b0;

    // PC trigger: the matching packet and later ones are captured.
    do_reset();
    pulse_start(1'b1);
    check("t2.armed", 64'(state_o), 64'd1);
    commit_one(32'h6000_0000);
    check("t2.armed0", 64'(state_o), 64'd1);
    commit_one(32'h6000_0004);
    check("t2.armed1", 64'(state_o), 64'd1);
    check("t2.occ0", 64'(occupancy), 64'd0);
    commit_one(32'h6000_0010);
    check("t2.capture", 64'(state_o), 64'd2);
    check("t2.cap1", 64'(capture_cnt), 64'd1);
    commit_one(32'h6000_0014);
    check("t2.occ", 64'(occupancy), 64'd2);
    check("t2.cap2", 64'(capture_cnt), 64'd2);
    drain_seq("t2", 2, 2);

    // Overflow: 20 commits into a stalled 16-entry FIFO.
    do_reset();
    pulse_start(1'b0);
    for (int i = 0; i < 20; i++) commit_one(32'h0000_2000 + 32'(4 * i));
    check("t3.occ", 64'(occupancy), 64'd16);
    check("t3.drop", 64'(drop_cnt), 64'd4);
    check("t3.ovf", 64'(overflow), 64'd1);
    check("t3.cap", 64'(capture_cnt), 64'd20);
    drain_seq("t3", 0, 16);

    // Refill, then push into a full FIFO while the head is popped.
    for (int i = 0; i < 16; i++) commit_one(32'h0000_3000 + 32'(4 * i));
    check("t4.occ", 64'(occupancy), 64'd16);
    check("t4.drop0", 64'(drop_cnt), 64'd4);
    @(negedge clk);
    commit_valid         = 1'b1;
    commit_word.pc_rdata = 32'h0000_3040;
    trace_ready          = 1'b1;
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
    trace_ready  = 1'b0;
    check("t4.occ_same", 64'(occupancy), 64'd16);
    check("t4.drop_same", 64'(drop_cnt), 64'd4);
    check("t4.head", trace_word.order, 64'd21);
    drain_seq("t4", 21, 16);

    // Capture limit of 3 and a restart from DONE.
    do_reset();
    cfg_limit   = 16'd3;
    trace_ready = 1'b1;
    pulse_start(1'b0);
    for (int i = 0; i < 3; i++) commit_one(32'h0000_4000 + 32'(4 * i));
    check("t5.cap", 64'(capture_cnt), 64'd3);
    check("t5.done", 64'(done), 64'd1);
    check("t5.state", 64'(state_o), 64'd3);
    for (int i = 3; i < 6; i++) commit_one(32'h0000_4000 + 32'(4 * i));
    check("t5.cap_hold", 64'(capture_cnt), 64'd3);
    check("t5.done_hold", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    check("t5.empty", 64'(trace_valid), 64'd0);
    pulse_start(1'b0);
    check("t5.cap_clr", 64'(capture_cnt), 64'd0);
    check("t5.restart", 64'(state_o), 64'd2);
    check("t5.done_clr", 64'(done), 64'd0);
    commit_one(32'h0000_4100);
    check("t5.valid", 64'(trace_valid), 64'd1);
    check("t5.order", trace_word.order, 64'd6);
    trace_ready = 1'b0;

    // Abort keeps queued packets; later commits are not captured.
    do_reset();
    cfg_limit = '0;
    pulse_start(1'b0);
    commit_one(32'h0000_5000);
    commit_one(32'h0000_5004);
    check("t6.occ", 64'(occupancy), 64'd2);
    pulse_abort();
    check("t6.idle", 64'(state_o), 64'd0);
    commit_one(32'h0000_5008);
    commit_one(32'h0000_500c);
    check("t6.occ_kept", 64'(occupancy), 64'd2);
    check("t6.cap", 64'(capture_cnt), 64'd2);
    drain_seq("t6", 0, 2);

    // Reset with entries queued flushes the FIFO.
    pulse_start(1'b0);
    commit_one(32'h0000_6000);
    commit_one(32'h0000_6004);
    check("t7.occ", 64'(occupancy), 64'd2);
    check("t7.order", trace_word.order, 64'd4);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("t7.valid", 64'(trace_valid), 64'd0);
    check("t7.occ0", 64'(occupancy), 64'd0);
    check("t7.state", 64'(state_o), 64'd0);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
